// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: the fetch-to-decode payload and queue index/count width helpers.
// Optional feature of id_issue_queue: ID_QUEUE_BYPASS_EN (same-cycle fetch-to-decode bypass).
package cpu_defs;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        excp;
  } fs_to_ds_bus_t;

  // Index width for a ring of n entries (at least one bit).
  function automatic int qidx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold any occupancy 0..n.
  function automatic int qcnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/id_queue_ram.sv
// Entry storage for the fetch-to-decode issue queue: multi-port write, asynchronous multi-port read.
// Write addresses within one cycle are always distinct, so port order never matters.
module id_queue_ram
  import cpu_defs::*;
#(
  parameter int DEPTH    = 8,
  parameter int WR_PORTS = 2,
  parameter int RD_PORTS = 2
) (
  input  logic                       clk,
  input  logic [WR_PORTS-1:0]        wr_en_i,
  input  logic [qidx_w(DEPTH)-1:0]   wr_addr_i [WR_PORTS],
  input  fs_to_ds_bus_t              wr_data_i [WR_PORTS],
  input  logic [qidx_w(DEPTH)-1:0]   rd_addr_i [RD_PORTS],
  output fs_to_ds_bus_t              rd_data_o [RD_PORTS]
);

  fs_to_ds_bus_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    for (int j = 0; j < WR_PORTS; j++) begin
      if (wr_en_i[j]) begin
        mem_q[wr_addr_i[j]] <= wr_data_i[j];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RD_PORTS; gi++) begin : g_rd
      assign rd_data_o[gi] = mem_q[rd_addr_i[gi]];
    end
  endgenerate

endmodule

// File: rtl/id_issue_queue.sv
// Fetch-to-decode issue queue: circular buffer, PUSH_W lanes in, POP_W lanes out, two flush flavours.
// Define ID_QUEUE_BYPASS_EN to let accepted fetch lanes reach decode in the same cycle.
module id_issue_queue
  import cpu_defs::*;
#(
  parameter int DEPTH  = 8,
  parameter int PUSH_W = 2,
  parameter int POP_W  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PUSH_W-1:0]          in_valid,
  input  fs_to_ds_bus_t              in_data [PUSH_W],
  output logic                       in_ready,
  output logic [POP_W-1:0]           out_valid,
  output fs_to_ds_bus_t              out_data [POP_W],
  input  logic [qcnt_w(POP_W)-1:0]   pop_cnt,
  input  logic                       flush_all,
  input  logic                       flush_keep_ds,
  output logic [qcnt_w(DEPTH)-1:0]   count
);

  localparam int IW = qidx_w(DEPTH);
  localparam int CW = qcnt_w(DEPTH);

  logic [IW-1:0]    head_q, head_d;
  logic [IW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    pushed;
  logic [CW-1:0]    pop_ext;
  logic [PUSH_W-1:0] wr_en;
  logic [IW-1:0]    wr_addr [PUSH_W];
  logic [IW-1:0]    rd_addr [POP_W];
  fs_to_ds_bus_t    rd_data [POP_W];

  // Ready depends on registered occupancy only, never on this cycle's pops.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(PUSH_W);
  assign pop_ext  = CW'(pop_cnt);
  assign count    = count_q;

  always_comb begin
    pushed = '0;
    for (int j = 0; j < PUSH_W; j++) begin
      if (in_ready && in_valid[j]) begin
        pushed = pushed + CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PUSH_W; gi++) begin : g_wr
      assign wr_addr[gi] = tail_q + IW'(gi);
`ifdef ID_QUEUE_BYPASS_EN
      // A lane consumed through the bypass this cycle never needs storing.
      assign wr_en[gi] = !reset && !flush_all && in_ready && in_valid[gi]
                         && ((count_q + CW'(gi)) >= pop_ext);
`else
      assign wr_en[gi] = !reset && !flush_all && in_ready && in_valid[gi];
`endif
    end

    for (gi = 0; gi < POP_W; gi++) begin : g_out
      logic          lane_vld;
      fs_to_ds_bus_t lane_data;

      assign rd_addr[gi] = head_q + IW'(gi);

`ifdef ID_QUEUE_BYPASS_EN
      always_comb begin
        lane_vld  = 1'b0;
        lane_data = rd_data[gi];
        if (count_q > CW'(gi)) begin
          lane_vld = 1'b1;
        end else begin
          for (int j = 0; j < PUSH_W; j++) begin
            if (in_ready && in_valid[j] && ((count_q + CW'(j)) == CW'(gi))) begin
              lane_vld  = 1'b1;
              lane_data = in_data[j];
            end
          end
        end
      end
`else
      assign lane_vld  = count_q > CW'(gi);
      assign lane_data = rd_data[gi];
`endif

      assign out_valid[gi] = lane_vld;
      assign out_data[gi]  = lane_data;
    end
  endgenerate

  id_queue_ram #(
    .DEPTH    (DEPTH),
    .WR_PORTS (PUSH_W),
    .RD_PORTS (POP_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (in_data),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    head_d  = head_q + IW'(pop_cnt);
    tail_d  = tail_q + IW'(pushed);
    count_d = count_q + pushed - pop_ext;
    if (flush_all) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (flush_keep_ds) begin
      // Keep only the delay slot: oldest surviving stored entry, else an unpopped lane 0.
      if (pop_ext < count_q) begin
        tail_d  = head_d + IW'(1);
        count_d = CW'(1);
      end else if ((pop_ext == count_q) && in_ready && in_valid[0]) begin
        head_d  = tail_q;
        tail_d  = tail_q + IW'(1);
        count_d = CW'(1);
      end else begin
        head_d  = tail_q;
        tail_d  = tail_q;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
`ifdef ID_QUEUE_BYPASS_EN
      assert (pop_ext <= (count_q + pushed));
`else
      assert (pop_ext <= count_q);
`endif
    end
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Randomized and directed bench for id_issue_queue against a queue-based reference model.
// Build with ID_QUEUE_BYPASS_EN defined to also exercise the same-cycle bypass.
module tb_id_issue_queue;
  import cpu_defs::*;

  localparam int DEPTH  = 8;
  localparam int PUSH_W = 2;
  localparam int POP_W  = 2;
  localparam int CW     = qcnt_w(DEPTH);
  localparam int PW     = qcnt_w(POP_W);

  logic              clk = 1'b0;
  logic              reset;
  logic [PUSH_W-1:0] in_valid;
  fs_to_ds_bus_t     in_data [PUSH_W];
  logic              in_ready;
  logic [POP_W-1:0]  out_valid;
  fs_to_ds_bus_t     out_data [POP_W];
  logic [PW-1:0]     pop_cnt;
  logic              flush_all;
  logic              flush_keep_ds;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  id_issue_queue #(
    .DEPTH  (DEPTH),
    .PUSH_W (PUSH_W),
    .POP_W  (POP_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .pop_cnt       (pop_cnt),
    .flush_all     (flush_all),
    .flush_keep_ds (flush_keep_ds),
    .count         (count)
  );

  int checks   = 0;
  int failures = 0;

  fs_to_ds_bus_t mq[$];     // model contents, oldest first
  fs_to_ds_bus_t lanes[$];  // lanes accepted in the current cycle
  int            cur_pop;
  bit            cur_fa, cur_fk;
  logic [31:0]   next_pc;

  task automatic check_eq(string tag, logic [95:0] got, logic [95:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_ready();
    return (DEPTH - mq.size()) >= PUSH_W;
  endfunction

  function automatic int visible_n(int npush);
    int v = mq.size();
`ifdef ID_QUEUE_BYPASS_EN
    if (model_ready()) v += npush;
`endif
    return v;
  endfunction

  // Apply one cycle of inputs (called just after a negedge) and check combinational outputs.
  task automatic drive(int npush, int pop, bit fa, bit fk);
    fs_to_ds_bus_t    vis[$];
    logic [POP_W-1:0] exp_v;
    lanes.delete();
    for (int j = 0; j < PUSH_W; j++) begin
      in_data[j].pc   = next_pc + 32'(4 * j);
      in_data[j].inst = $urandom;
      in_data[j].excp = 1'($urandom_range(0, 1));
      in_valid[j]     = (j < npush);
      if ((j < npush) && model_ready()) lanes.push_back(in_data[j]);
    end
    next_pc       = next_pc + 32'(4 * lanes.size());
    pop_cnt       = PW'(pop);
    flush_all     = fa;
    flush_keep_ds = fk;
    cur_pop       = pop;
    cur_fa        = fa;
    cur_fk        = fk;
    #1;
    vis = mq;
`ifdef ID_QUEUE_BYPASS_EN
    vis = {mq, lanes};
`endif
    exp_v = '0;
    for (int i = 0; i < POP_W; i++) if (i < vis.size()) exp_v[i] = 1'b1;
    check_eq("count", 96'(count), 96'(mq.size()));
    check_eq("in_ready", 96'(in_ready), 96'(model_ready()));
    check_eq("out_valid", 96'(out_valid), 96'(exp_v));
    for (int i = 0; i < POP_W; i++) begin
      if (i < vis.size()) check_eq($sformatf("out_data%0d", i), 96'(out_data[i]), 96'(vis[i]));
    end
  endtask

  // Clock the cycle and advance the model by the queue rules.
  task automatic commit();
    fs_to_ds_bus_t all[$];
    int            nstored;
    nstored = mq.size();
    @(posedge clk);
    all = {mq, lanes};
    if (cur_fa) begin
      mq.delete();
    end else if (cur_fk) begin
      mq.delete();
      if (cur_pop < nstored) mq.push_back(all[cur_pop]);
      else if ((cur_pop == nstored) && (lanes.size() > 0)) mq.push_back(lanes[0]);
    end else begin
      mq = all;
      for (int k = 0; k < cur_pop; k++) void'(mq.pop_front());
    end
    @(negedge clk);
  endtask

  // Reset with push and flush also active: reset must win.
  task automatic do_reset();
    reset         = 1'b1;
    in_valid      = '1;
    flush_keep_ds = 1'b1;
    flush_all     = 1'b0;
    pop_cnt       = '0;
    @(posedge clk);
    mq.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = '0;
    pop_cnt       = '0;
    flush_all     = 1'b0;
    flush_keep_ds = 1'b0;
    next_pc       = 32'h100;
    for (int j = 0; j < PUSH_W; j++) in_data[j] = '0;

    do_reset();
    drive(0, 0, 0, 0);
    check_eq("rst_count", 96'(count), 96'(0));
    check_eq("rst_ready", 96'(in_ready), 96'(1));
    check_eq("rst_valid", 96'(out_valid), 96'(0));
    commit();

    // Fill to full, then an ignored push.
    next_pc = 32'h1000;
    for (int c = 0; c < 4; c++) begin
      drive(2, 0, 0, 0);
      commit();
    end
    drive(2, 0, 0, 0);
    check_eq("full_count", 96'(count), 96'(DEPTH));
    check_eq("full_ready", 96'(in_ready), 96'(0));
    commit();
    drive(0, 0, 0, 0);
    check_eq("full_ignored", 96'(count), 96'(DEPTH));
    check_eq("full_head_pc", 96'(out_data[0].pc), 96'(32'h1000));
    commit();

    // Steady-state push 2 / pop 2 across the wrap point.
    do_reset();
    next_pc = 32'h4000;
    for (int c = 0; c < 3; c++) begin
      drive(2, 0, 0, 0);
      commit();
    end
    for (int c = 0; c < 10; c++) begin
      drive(2, 2, 0, 0);
      check_eq("wrap_pc0", 96'(out_data[0].pc), 96'(32'h4000 + 32'(8 * c)));
      check_eq("wrap_pc1", 96'(out_data[1].pc), 96'(32'h4004 + 32'(8 * c)));
      commit();
      check_eq("wrap_count", 96'(count), 96'(6));
    end

    // flush_all with pops and pushes in flight.
    do_reset();
    next_pc = 32'h5000;
    drive(2, 0, 0, 0); commit();
    drive(2, 0, 0, 0); commit();
    drive(1, 0, 0, 0); commit();
    drive(2, 2, 1, 0); commit();
    drive(0, 0, 0, 0);
    check_eq("fa_count", 96'(count), 96'(0));
    check_eq("fa_valid", 96'(out_valid), 96'(0));
    commit();

    // flush_keep_ds keeps oldest surviving stored entry.
    do_reset();
    next_pc = 32'h2000;
    drive(2, 0, 0, 0); commit();
    drive(2, 0, 0, 0); commit();
    drive(0, 1, 0, 1); commit();
    drive(0, 0, 0, 0);
    check_eq("fk_count", 96'(count), 96'(1));
    check_eq("fk_pc", 96'(out_data[0].pc), 96'(32'h2004));
    commit();

    // flush_keep_ds on empty queue keeps pushing lane 0 only.
    do_reset();
    next_pc = 32'h3000;
    drive(2, 0, 0, 1); commit();
    drive(0, 0, 0, 0);
    check_eq("fk_push_count", 96'(count), 96'(1));
    check_eq("fk_push_pc", 96'(out_data[0].pc), 96'(32'h3000));
    commit();

`ifdef ID_QUEUE_BYPASS_EN
    do_reset();
    next_pc = 32'hBFC00000;
    drive(1, 1, 0, 0);
    check_eq("byp_valid", 96'(out_valid[0]), 96'(1));
    check_eq("byp_pc", 96'(out_data[0].pc), 96'(32'hBFC00000));
    commit();
    drive(0, 0, 0, 0);
    check_eq("byp_count", 96'(count), 96'(0));
    commit();
`endif

    // Randomized traffic against the model.
    do_reset();
    next_pc = 32'h8000_0000;
    for (int c = 0; c < 500; c++) begin
      int npush, vis, maxp, pop;
      bit fa, fk;
      if ($urandom_range(0, 199) == 0) do_reset();
      npush = int'($urandom_range(0, PUSH_W));
      vis   = visible_n(npush);
      maxp  = (vis < POP_W) ? vis : POP_W;
      pop   = int'($urandom_range(0, maxp));
      fa    = ($urandom_range(0, 24) == 0);
      fk    = !fa && ($urandom_range(0, 14) == 0);
      drive(npush, pop, fa, fk);
      commit();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_issue_queue.md
ID_ISSUE_QUEUE -- requirements
Module: id_issue_queue

Interface
REQ-001 Parameter DEPTH, default 8, entries held; power of two, >= 4.
REQ-002 Parameter PUSH_W, default 2, fetch lanes accepted per cycle; 1..DEPTH/2.
REQ-003 Parameter POP_W, default 2, decode lanes presented per cycle; 1..DEPTH/2.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  PUSH_W  per-lane push request; lanes contiguous from lane 0.
REQ-007 in_data  in  PUSH_W x fs_to_ds_bus_t  fetch payload, lane 0 oldest.
REQ-008 in_ready  out  1  high when free entries >= PUSH_W.
REQ-009 out_valid  out  POP_W  lane i high when count > i.
REQ-010 out_data  out  POP_W x fs_to_ds_bus_t  entries head..head+POP_W-1.
REQ-011 pop_cnt  in  clog2(POP_W+1)  entries consumed by decode this cycle.
REQ-012 flush_all  in  1  exception/eret flush (pipeline_flush.ex | .eret).
REQ-013 flush_keep_ds  in  1  branch-mispredict flush that preserves the delay slot.
REQ-014 count  out  clog2(DEPTH+1)  current occupancy.

Function
REQ-015 Storage: circular buffer, head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH; count register authoritative for full/empty.
REQ-016 Push accepted only when in_ready; accepted lanes = popcount(in_valid); written at tail, tail += accepted.
REQ-017 Pop: head += pop_cnt, same cycle as push; new count = count + pushed - pop_cnt.
REQ-018 pop_cnt > count is illegal; design asserts in simulation, behaviour undefined.
REQ-019 in_ready computed from registered count only (no combinational path from pop_cnt).
REQ-020 Full: in_ready low when DEPTH - count < PUSH_W; in_valid ignored.
REQ-021 Empty: out_valid all zero; pop_cnt must be 0.
REQ-022 Latency: pushed entry visible on out_data the cycle after acceptance (bypass off).
REQ-023 flush_all (priority over flush_keep_ds): next cycle count=0, head=tail=0; this cycle's pushes discarded.
REQ-024 flush_keep_ds: after this cycle's pops, if >=1 entry remains, keep only the oldest remaining (delay slot), count=1; else if lane 0 pushes this cycle, keep that lane only, count=1; else count=0.
REQ-025 flush_keep_ds with pushes: all pushed lanes except the REQ-024 retained one discarded.
REQ-026 Pointer wrap-around with simultaneous push and pop at DEPTH boundary preserves FIFO order.

Reset
REQ-027 On reset: count=0, head=tail=0, out_valid=0, in_ready=1; in_data ignored.
REQ-028 Reset overrides flush and push in the same cycle; storage array contents not reset.

Configuration
REQ-029 Macro ID_QUEUE_BYPASS_EN: when defined, with count < POP_W, accepted in_data lanes appear combinationally on out_data lanes count.. and may be popped same cycle (pop_cnt up to count+pushed); bypassed-and-popped lanes are not written.
REQ-030 Without ID_QUEUE_BYPASS_EN: no in-to-out combinational path; REQ-022 latency holds.

Structure
REQ-031 fs_to_ds_bus_t and queue index/count width functions reside in the shared cpu_defs package; no new structs local to the module.
REQ-032 One sub-module: id_queue_ram (DEPTH x fs_to_ds_bus_t, PUSH_W write ports, POP_W read ports, async read).

Verification
REQ-033 DEPTH=8,PUSH_W=2: push 2/cycle for 4 cycles, no pops -> count=8, in_ready=0 cycle 4; 5th push ignored.
REQ-034 Fill 6, pop 2 and push 2 each cycle for 10 cycles (wraps) -> PC order on out_data strictly sequential, count stays 6.
REQ-035 count=5, flush_all with pop_cnt=2 and 2 pushes -> next cycle count=0, out_valid=0.
REQ-036 count=4 (PCs A..D), flush_keep_ds with pop_cnt=1 -> next cycle count=1, out_data[0].pc=B.
REQ-037 count=0, flush_keep_ds with lane0 pushing PC E, lane1 PC F -> next cycle count=1, out_data[0].pc=E.
REQ-038 ID_QUEUE_BYPASS_EN defined, empty, push PC 0xBFC00000 with pop_cnt=1 -> out_data[0] matches same cycle, next cycle count=0.
